mux_rr_arbiter: RTL

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Two-input round-robin arbiter with burst limit feeding a registered
// output stage; one transfer per cycle when downstream is ready.
module mux_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_sel,
  input  logic             y_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_t;

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_a_q, last_a_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_sel_q, y_sel_d;

  logic gnt_a, gnt_b;
  logic below;
  logic load_en;
  logic xfer_a, xfer_b;

  assign below   = cnt_q < CMAX;
  assign load_en = !y_valid_q || y_ready;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          gnt_a = !last_a_q;
          gnt_b = last_a_q;
        end else begin
          gnt_a = a_valid;
          gnt_b = b_valid;
        end
      end
      SERVE_A: begin
        if (a_valid && (below || !b_valid)) gnt_a = 1'b1;
        else gnt_b = b_valid;
      end
      SERVE_B: begin
        if (b_valid && (below || !a_valid)) gnt_b = 1'b1;
        else gnt_a = a_valid;
      end
      default: ;
    endcase
  end

  // Ready is gated by rst_n so nothing handshakes while reset is held.
  assign xfer_a  = rst_n && load_en && gnt_a;
  assign xfer_b  = rst_n && load_en && gnt_b;
  assign a_ready = xfer_a;
  assign b_ready = xfer_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_a_d  = last_a_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_sel_d   = y_sel_q;
    if (load_en) begin
      y_valid_d = xfer_a || xfer_b;
      if (xfer_a) begin
        y_data_d = a_data;
        y_sel_d  = 1'b1;
        if (state_q == SERVE_A) begin
          cnt_d = below ? cnt_q + ONE : ONE;
        end else begin
          state_d  = SERVE_A;
          cnt_d    = ONE;
          last_a_d = 1'b1;
        end
      end else if (xfer_b) begin
        y_data_d = b_data;
        y_sel_d  = 1'b0;
        if (state_q == SERVE_B) begin
          cnt_d = below ? cnt_q + ONE : ONE;
        end else begin
          state_d  = SERVE_B;
          cnt_d    = ONE;
          last_a_d = 1'b0;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_a_q  <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_sel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_a_q  <= last_a_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_sel_q   <= y_sel_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_sel   = y_sel_q;

endmodule
